// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo widths, frame length, threshold limits and clamp
package servo_pkg;

    localparam int THRES_W = 15;
    localparam int FRAME_US = 20000;

    localparam logic [THRES_W-1:0] THRES_MIN  = 15'd500;
    localparam logic [THRES_W-1:0] THRES_MAX  = 15'd2500;
    localparam logic [THRES_W-1:0] THRES_INIT = 15'd1500;

    function automatic logic [THRES_W-1:0] clamp_pos(input logic [THRES_W-1:0] pos);
        if (pos < THRES_MIN) begin
            return THRES_MIN;
        end else if (pos > THRES_MAX) begin
            return THRES_MAX;
        end
        return pos;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - free-running PWM frame counter with start and last-cycle strobes
import servo_pkg::*;

module servo_frame_timer #(
    parameter int FRAME_US = servo_pkg::FRAME_US
) (
    input  logic clk_1us,
    input  logic rst_n,
    output logic o_frame_tick,
    output logic o_last
);

    localparam logic [THRES_W-1:0] LAST_CNT = THRES_W'(FRAME_US - 1);

    logic [THRES_W-1:0] r_count;

    always_ff @(posedge clk_1us or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_count == LAST_CNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_frame_tick = (r_count == '0);
    assign o_last       = (r_count == LAST_CNT);

endmodule

// File: rtl/servo_slew_ctrl.sv
// rtl/servo_slew_ctrl.sv - arbitrated, clamped, per-frame slew-limited servo threshold scheduler
import servo_pkg::*;

module servo_slew_ctrl #(
    parameter int FRAME_US = servo_pkg::FRAME_US
) (
    input  logic               clk_1us,
    input  logic               rst_n,
    input  logic               a_valid,
    input  logic [THRES_W-1:0] a_pos,
    output logic               a_ready,
    input  logic               m_valid,
    input  logic [THRES_W-1:0] m_pos,
    output logic               m_ready,
    input  logic [7:0]         step_cfg,
    output logic [THRES_W-1:0] pwm_thres,
    output logic               frame_tick,
    output logic               at_target,
    output logic               cmd_src
);

    logic                      w_last;
    logic                      w_a_acc;
    logic                      w_m_acc;
    logic [THRES_W-1:0]        w_eff;
    logic [THRES_W-1:0]        w_step;
    logic [THRES_W-1:0]        w_next;
    logic signed [THRES_W:0]   w_diff;
    logic [THRES_W:0]          w_abs;

    logic [THRES_W-1:0]        r_thres;
    logic [THRES_W-1:0]        r_target;
    logic [THRES_W-1:0]        r_pend_pos;
    logic                      r_pend_v;
    logic                      r_cmd_src;

    servo_frame_timer #(
        .FRAME_US(FRAME_US)
    ) u_frame_timer (
        .clk_1us     (clk_1us),
        .rst_n       (rst_n),
        .o_frame_tick(frame_tick),
        .o_last      (w_last)
    );

    // Manual wins outright; auto only sees ready when it can actually be taken.
    assign m_ready = !r_pend_v;
    assign a_ready = !r_pend_v && !m_valid;
    assign w_m_acc = m_valid && m_ready;
    assign w_a_acc = a_valid && a_ready;

    assign w_eff  = r_pend_v ? r_pend_pos : r_target;
    assign w_diff = $signed({1'b0, w_eff}) - $signed({1'b0, r_thres});
    assign w_abs  = w_diff[THRES_W] ? unsigned'(-w_diff) : unsigned'(w_diff);
    assign w_step = {{(THRES_W-8){1'b0}}, step_cfg};

    always_comb begin
        w_next = w_eff;
        if (step_cfg != 8'd0 && w_abs > {1'b0, w_step}) begin
            w_next = w_diff[THRES_W] ? (r_thres - w_step) : (r_thres + w_step);
        end
    end

    // A command taken on the update edge itself lands in the pending slot for next frame.
    always_ff @(posedge clk_1us or negedge rst_n) begin
        if (!rst_n) begin
            r_thres    <= THRES_INIT;
            r_target   <= THRES_INIT;
            r_pend_pos <= THRES_INIT;
            r_pend_v   <= 1'b0;
            r_cmd_src  <= 1'b0;
        end else begin
            if (w_last) begin
                r_target <= w_eff;
                r_thres  <= w_next;
                r_pend_v <= 1'b0;
            end
            if (w_m_acc || w_a_acc) begin
                r_pend_pos <= clamp_pos(w_m_acc ? m_pos : a_pos);
                r_pend_v   <= 1'b1;
                r_cmd_src  <= w_m_acc;
            end
        end
    end

    assign pwm_thres = r_thres;
    assign cmd_src   = r_cmd_src;
    assign at_target = (r_thres == r_target) && !r_pend_v;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// tb/tb_servo_slew_ctrl.sv - scoreboard bench for servo_slew_ctrl with a shortened frame
module tb_servo_slew_ctrl;

    localparam int FR = 100;

    logic        clk_1us = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic [14:0] a_pos = '0;
    logic        a_ready;
    logic        m_valid = 1'b0;
    logic [14:0] m_pos = '0;
    logic        m_ready;
    logic [7:0]  step_cfg = '0;
    logic [14:0] pwm_thres;
    logic        frame_tick;
    logic        at_target;
    logic        cmd_src;

    int tests = 0;
    int fails = 0;
    int tb_cnt;
    int exp_q[$];
    logic [14:0] prev_thres;

    servo_slew_ctrl #(.FRAME_US(FR)) dut (
        .clk_1us   (clk_1us),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_pos     (a_pos),
        .a_ready   (a_ready),
        .m_valid   (m_valid),
        .m_pos     (m_pos),
        .m_ready   (m_ready),
        .step_cfg  (step_cfg),
        .pwm_thres (pwm_thres),
        .frame_tick(frame_tick),
        .at_target (at_target),
        .cmd_src   (cmd_src)
    );

    always #5 clk_1us = ~clk_1us;

    always @(posedge clk_1us or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == FR - 1) ? 0 : tb_cnt + 1;
    end

    always @(negedge clk_1us) begin
        tests++;
        if (frame_tick !== (tb_cnt == 0)) begin
            fails++;
            $display("FAIL frame_tick cnt=%0d got %b want %b", tb_cnt, frame_tick, tb_cnt == 0);
        end
        if (tb_cnt != 0 && rst_n) begin
            tests++;
            if (pwm_thres !== prev_thres) begin
                fails++;
                $display("FAIL thres_hold cnt=%0d got %0d want %0d", tb_cnt, pwm_thres, prev_thres);
            end
        end
        prev_thres = pwm_thres;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    task automatic wait_count(input int c);
        int n = 0;
        while (tb_cnt != c && n < 2 * FR) begin
            @(negedge clk_1us);
            n++;
        end
    endtask

    task automatic check_update(input string nm);
        int e;
        @(negedge clk_1us);
        wait_count(0);
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s got %0d want <empty scoreboard>", nm, pwm_thres);
        end else begin
            e = exp_q.pop_front();
            if (pwm_thres !== 15'(e)) begin
                fails++;
                $display("FAIL %s got %0d want %0d", nm, pwm_thres, e);
            end
        end
    endtask

    task automatic send(input bit manual, input int pos);
        if (manual) begin m_valid = 1'b1; m_pos = 15'(pos); end
        else        begin a_valid = 1'b1; a_pos = 15'(pos); end
        @(negedge clk_1us);
        m_valid = 1'b0;
        a_valid = 1'b0;
    endtask

    task automatic test_reset;
        int ticks = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_1us);
        tests++;
        if (pwm_thres !== 15'd1500 || at_target !== 1'b1 || cmd_src !== 1'b0 ||
            a_ready !== 1'b1 || m_ready !== 1'b1 || frame_tick !== 1'b1) begin
            fails++;
            $display("FAIL reset_vals got thres=%0d at=%b src=%b ar=%b mr=%b ft=%b want 1500 1 0 1 1 1",
                     pwm_thres, at_target, cmd_src, a_ready, m_ready, frame_tick);
        end
        rst_n = 1'b1;
        repeat (3 * FR) begin
            @(negedge clk_1us);
            if (frame_tick) ticks++;
            tests++;
            if (pwm_thres !== 15'd1500 || at_target !== 1'b1) begin
                fails++;
                $display("FAIL idle got thres=%0d at=%b want 1500 1", pwm_thres, at_target);
            end
        end
        tests++;
        if (ticks != 3) begin
            fails++;
            $display("FAIL tick_count got %0d want 3", ticks);
        end
    endtask

    task automatic test_ramp;
        step_cfg = 8'd20;
        wait_count(50);
        a_valid = 1'b1;
        a_pos = 15'd1600;
        #1;
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL ramp_a_ready got %b want 1", a_ready);
        end
        @(negedge clk_1us);
        a_valid = 1'b0;
        tests++;
        if (cmd_src !== 1'b0 || at_target !== 1'b0 || a_ready !== 1'b0) begin
            fails++;
            $display("FAIL ramp_accept got src=%b at=%b ar=%b want 0 0 0", cmd_src, at_target, a_ready);
        end
        for (int v = 1520; v <= 1600; v += 20) exp_q.push_back(v);
        for (int i = 0; i < 5; i++) begin
            check_update("ramp_step");
            tests++;
            if (at_target !== (i == 4)) begin
                fails++;
                $display("FAIL ramp_at_target step=%0d got %b want %b", i, at_target, i == 4);
            end
        end
    endtask

    task automatic test_priority;
        step_cfg = 8'd0;
        wait_count(10);
        a_valid = 1'b1; a_pos = 15'd800;
        m_valid = 1'b1; m_pos = 15'd2200;
        #1;
        tests++;
        if (m_ready !== 1'b1 || a_ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_ready got mr=%b ar=%b want 1 0", m_ready, a_ready);
        end
        @(negedge clk_1us);
        m_valid = 1'b0;
        #1;
        tests++;
        if (cmd_src !== 1'b1 || m_ready !== 1'b0 || a_ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_pending got src=%b mr=%b ar=%b want 1 0 0", cmd_src, m_ready, a_ready);
        end
        exp_q.push_back(2200);
        check_update("prio_manual");
        #1;
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL prio_auto_ready got %b want 1", a_ready);
        end
        exp_q.push_back(800);
        @(negedge clk_1us);
        a_valid = 1'b0;
        tests++;
        if (cmd_src !== 1'b0) begin
            fails++;
            $display("FAIL prio_auto_src got %b want 0", cmd_src);
        end
        check_update("prio_auto");
    endtask

    task automatic test_clamp;
        step_cfg = 8'd0;
        send(1'b1, 3000);  exp_q.push_back(2500); check_update("clamp_high");
        send(1'b0, 100);   exp_q.push_back(500);  check_update("clamp_low");
        send(1'b0, 32767); exp_q.push_back(2500); check_update("clamp_max15");
        send(1'b1, 500);   exp_q.push_back(500);  check_update("clamp_edge");
    endtask

    task automatic test_retarget;
        step_cfg = 8'd0;
        send(1'b1, 700);
        exp_q.push_back(700);
        check_update("retgt_start");
        step_cfg = 8'd50;
        send(1'b0, 1000);
        exp_q.push_back(750);
        check_update("retgt_up");
        wait_count(40);
        send(1'b0, 600);
        exp_q.push_back(700); exp_q.push_back(650); exp_q.push_back(600);
        repeat (3) check_update("retgt_down");
        tests++;
        if (at_target !== 1'b1) begin
            fails++;
            $display("FAIL retgt_at_target got %b want 1", at_target);
        end
    endtask

    task automatic test_last_cycle;
        step_cfg = 8'd0;
        wait_count(FR - 1);
        m_valid = 1'b1;
        m_pos = 15'd1200;
        #1;
        tests++;
        if (m_ready !== 1'b1) begin
            fails++;
            $display("FAIL last_ready got %b want 1", m_ready);
        end
        @(negedge clk_1us);
        m_valid = 1'b0;
        tests++;
        if (pwm_thres !== 15'd600 || at_target !== 1'b0) begin
            fails++;
            $display("FAIL last_not_applied got thres=%0d at=%b want 600 0", pwm_thres, at_target);
        end
        exp_q.push_back(1200);
        check_update("last_applied");
    endtask

    task automatic test_reset_mid_ramp;
        rst_n = 1'b0;
        @(negedge clk_1us);
        rst_n = 1'b1;
        step_cfg = 8'd10;
        wait_count(5);
        send(1'b1, 2000);
        exp_q.push_back(1510);
        check_update("rst_ramp_first");
        wait_count(50);
        rst_n = 1'b0;
        #1;
        tests++;
        if (pwm_thres !== 15'd1500 || frame_tick !== 1'b1 || at_target !== 1'b1 ||
            a_ready !== 1'b1 || m_ready !== 1'b1 || cmd_src !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid got thres=%0d ft=%b at=%b ar=%b mr=%b src=%b want 1500 1 1 1 1 0",
                     pwm_thres, frame_tick, at_target, a_ready, m_ready, cmd_src);
        end
        repeat (2) @(negedge clk_1us);
        rst_n = 1'b1;
        exp_q.push_back(1500);
        exp_q.push_back(1500);
        repeat (2) check_update("rst_no_ramp");
        tests++;
        if (at_target !== 1'b1) begin
            fails++;
            $display("FAIL rst_at_target got %b want 1", at_target);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_priority();
        test_clamp();
        test_retarget();
        test_last_cycle();
        test_reset_mid_ramp();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
